// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, totals helper and control-bit bundle
package vga_pkg;

   // 640x480@60 with a 25.175 MHz pixel clock
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_COLOR_W  = 8;

   function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

   localparam int VGA_H_TOTAL = vga_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
   localparam int VGA_V_TOTAL = vga_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
   } vga_ctrl_t;

   localparam int VGA_CTRL_W = $bits(vga_ctrl_t);

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - clearable shift register; DEPTH = 0 degenerates to a wire
module vga_delay_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ctrl;
         assign unused_ctrl = &{1'b0, clk, reset, clear};
         assign dout = din;
      end else begin : g_shift
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk) begin
            if (!reset || clear) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage[i] <= '0;
               end
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_output.sv
// rtl/vga_timing_output.sv - VGA timing generator and output stage aligned to the pixel generator latency
module vga_timing_output
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int COLOR_W  = VGA_COLOR_W,
   parameter int LATENCY  = 2,
   parameter int X_W      = 10,
   parameter int Y_W      = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [COLOR_W-1:0] color_in,
   output logic [X_W-1:0]     pixel_x,
   output logic [Y_W-1:0]     pixel_y,
   output logic               pixel_req,
   output logic               frame_start,
   output logic               line_start,
   output logic [COLOR_W-1:0] color,
   output logic               de,
   output logic               HSync,
   output logic               VSync
);

   localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

   localparam logic [X_W-1:0] H_LAST      = X_W'(H_TOTAL - 1);
   localparam logic [X_W-1:0] H_ACT_END   = X_W'(H_ACTIVE);
   localparam logic [X_W-1:0] H_SYNC_BEG  = X_W'(H_ACTIVE + H_FP);
   localparam logic [X_W-1:0] H_SYNC_END  = X_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [Y_W-1:0] V_LAST      = Y_W'(V_TOTAL - 1);
   localparam logic [Y_W-1:0] V_ACT_END   = Y_W'(V_ACTIVE);
   localparam logic [Y_W-1:0] V_SYNC_BEG  = Y_W'(V_ACTIVE + V_FP);
   localparam logic [Y_W-1:0] V_SYNC_END  = Y_W'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic H_LVL = 1'(H_POL);
   localparam logic V_LVL = 1'(V_POL);

   logic [X_W-1:0] h_cnt;
   logic [Y_W-1:0] v_cnt;
   logic           h_wrap;
   logic           v_wrap;

   vga_ctrl_t ctrl_s0;
   vga_ctrl_t ctrl_d;

   assign h_wrap = (h_cnt == H_LAST);
   assign v_wrap = (v_cnt == V_LAST);

   // enable low parks the counters at the origin so restart is always a fresh frame
   always_ff @(posedge clk) begin
      if (!reset || !enable) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_wrap) begin
         h_cnt <= '0;
         v_cnt <= v_wrap ? '0 : v_cnt + Y_W'(1);
      end else begin
         h_cnt <= h_cnt + X_W'(1);
      end
   end

   always_comb begin
      ctrl_s0        = '0;
      ctrl_s0.active = enable && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      ctrl_s0.hs     = enable && (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
      ctrl_s0.vs     = enable && (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
   end

   assign pixel_x     = h_cnt;
   assign pixel_y     = v_cnt;
   assign pixel_req   = ctrl_s0.active;
   assign line_start  = enable && (h_cnt == '0);
   assign frame_start = enable && (h_cnt == '0) && (v_cnt == '0);

   // matches the generator's pipeline so sync/de meet the colour they belong to
   vga_delay_line #(
      .WIDTH (VGA_CTRL_W),
      .DEPTH (LATENCY)
   ) u_ctrl_delay (
      .clk   (clk),
      .reset (reset),
      .clear (!enable),
      .din   (ctrl_s0),
      .dout  (ctrl_d)
   );

   always_ff @(posedge clk) begin
      if (!reset || !enable) begin
         color <= '0;
         de    <= 1'b0;
         HSync <= ~H_LVL;
         VSync <= ~V_LVL;
      end else begin
         de    <= ctrl_d.active;
         color <= ctrl_d.active ? color_in : '0;
         HSync <= ctrl_d.hs ? H_LVL : ~H_LVL;
         VSync <= ctrl_d.vs ? V_LVL : ~V_LVL;
      end
   end

endmodule

// File: tb/tb_vga_timing_output.sv
// tb/tb_vga_timing_output.sv - randomized bench for three vga_timing_output configurations against a position-count model
module tb_vga_timing_output;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic enable;

   logic [7:0] c_in0, color0;
   logic [9:0] px0, py0;
   logic       req0, fs0, ls0, de0, hs0, vs0;

   logic [3:0] c_in1, color1;
   logic [2:0] px1, py1;
   logic       req1, fs1, ls1, de1, hs1, vs1;

   logic [7:0] c_in2, color2;
   logic [5:0] px2;
   logic [3:0] py2;
   logic       req2, fs2, ls2, de2, hs2, vs2;

   vga_timing_output #(.LATENCY(0)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .color_in(c_in0),
      .pixel_x(px0), .pixel_y(py0), .pixel_req(req0), .frame_start(fs0), .line_start(ls0),
      .color(color0), .de(de0), .HSync(hs0), .VSync(vs0));

   vga_timing_output #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1), .V_POL(1), .COLOR_W(4), .LATENCY(3), .X_W(3), .Y_W(3)
   ) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .color_in(c_in1),
      .pixel_x(px1), .pixel_y(py1), .pixel_req(req1), .frame_start(fs1), .line_start(ls1),
      .color(color1), .de(de1), .HSync(hs1), .VSync(vs1));

   vga_timing_output #(
      .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .H_POL(0), .V_POL(0), .COLOR_W(8), .LATENCY(2), .X_W(6), .Y_W(4)
   ) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .color_in(c_in2),
      .pixel_x(px2), .pixel_y(py2), .pixel_req(req2), .frame_start(fs2), .line_start(ls2),
      .color(color2), .de(de2), .HSync(hs2), .VSync(vs2));

   int ha [3]   = '{640, 4, 20};
   int hf [3]   = '{16, 1, 3};
   int hsw [3]  = '{96, 2, 5};
   int hb [3]   = '{48, 1, 4};
   int va [3]   = '{480, 3, 6};
   int vf [3]   = '{10, 1, 2};
   int vsw [3]  = '{2, 1, 2};
   int vb [3]   = '{33, 1, 3};
   int hpol [3] = '{0, 1, 0};
   int vpol [3] = '{0, 1, 0};
   int cw [3]   = '{8, 4, 8};
   int lat [3]  = '{0, 3, 2};

   int checks = 0;
   int failures = 0;
   int n [3];
   int hx [3][16];
   int hy [3][16];
   int de_cnt = 0;
   int vs_cnt = 0;
   bit wait_expired = 1'b0;
   bit wait_reported = 1'b0;

   function automatic int htot(input int i);
      return ha[i] + hf[i] + hsw[i] + hb[i];
   endfunction

   function automatic int vtot(input int i);
      return va[i] + vf[i] + vsw[i] + vb[i];
   endfunction

   function automatic bit in_active(input int i, input int x, input int y);
      return (x < ha[i]) && (y < va[i]);
   endfunction

   function automatic bit in_hs(input int i, input int x);
      return (x >= ha[i] + hf[i]) && (x < ha[i] + hf[i] + hsw[i]);
   endfunction

   function automatic bit in_vs(input int i, input int y);
      return (y >= va[i] + vf[i]) && (y < va[i] + vf[i] + vsw[i]);
   endfunction

   function automatic int color_fn(input int i, input int x, input int y);
      return (x * 5 + y * 17 + 60) & ((1 << cw[i]) - 1);
   endfunction

   task automatic check(input string name, input int inst, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s dut%0d n=%0d: got %0d expected %0d", name, inst, n[inst], act, exp);
      end
   endtask

   // n counts enabled edges since the last clearing edge; position and outputs follow from it
   always begin : compare_proc
      bit re, ee, clr;
      int ox [3], oy [3], oreq [3], ofs [3], ols [3], ode [3], ocol [3], ohs [3], ovs [3];
      int h, v, m, lh, lv, col_e, gx, gy, gc;
      bit a_e, hs_e, vs_e;
      @(posedge clk);
      re = reset;
      ee = enable;
      @(negedge clk);
      #1;
      ox[0] = int'(px0); oy[0] = int'(py0); oreq[0] = int'(req0); ofs[0] = int'(fs0); ols[0] = int'(ls0);
      ode[0] = int'(de0); ocol[0] = int'(color0); ohs[0] = int'(hs0); ovs[0] = int'(vs0);
      ox[1] = int'(px1); oy[1] = int'(py1); oreq[1] = int'(req1); ofs[1] = int'(fs1); ols[1] = int'(ls1);
      ode[1] = int'(de1); ocol[1] = int'(color1); ohs[1] = int'(hs1); ovs[1] = int'(vs1);
      ox[2] = int'(px2); oy[2] = int'(py2); oreq[2] = int'(req2); ofs[2] = int'(fs2); ols[2] = int'(ls2);
      ode[2] = int'(de2); ocol[2] = int'(color2); ohs[2] = int'(hs2); ovs[2] = int'(vs2);
      clr = !re || !ee;

      for (int i = 0; i < 3; i++) begin
         n[i] = clr ? 0 : n[i] + 1;
         h = n[i] % htot(i);
         v = (n[i] / htot(i)) % vtot(i);
         check("pixel_x", i, ox[i], h);
         check("pixel_y", i, oy[i], v);
         check("pixel_req", i, oreq[i], (enable && in_active(i, h, v)) ? 1 : 0);
         check("frame_start", i, ofs[i], (enable && h == 0 && v == 0) ? 1 : 0);
         check("line_start", i, ols[i], (enable && h == 0) ? 1 : 0);
         m = n[i] - 1 - lat[i];
         a_e = 1'b0; hs_e = 1'b0; vs_e = 1'b0; col_e = 0;
         if (!clr && m >= 0) begin
            lh = m % htot(i);
            lv = (m / htot(i)) % vtot(i);
            a_e = in_active(i, lh, lv);
            hs_e = in_hs(i, lh);
            vs_e = in_vs(i, lv);
            col_e = a_e ? color_fn(i, lh, lv) : 0;
         end
         check("de", i, ode[i], a_e ? 1 : 0);
         check("color", i, ocol[i], col_e);
         check("HSync", i, ohs[i], hs_e ? hpol[i] : 1 - hpol[i]);
         check("VSync", i, ovs[i], vs_e ? vpol[i] : 1 - vpol[i]);
      end

      if (clr) begin
         check("idle_de0", 0, ode[0], 0);
         check("idle_hsync0", 0, ohs[0], 1);
         check("idle_vsync0", 0, ovs[0], 1);
         check("idle_hsync1", 1, ohs[1], 0);
         check("idle_vsync1", 1, ovs[1], 0);
         check("idle_color2", 2, ocol[2], 0);
      end
      if (n[0] == 656) check("hsync_pre_pulse", 0, ohs[0], 1);
      if (n[0] == 657) check("hsync_pulse_first", 0, ohs[0], 0);
      if (n[0] == 752) check("hsync_pulse_last", 0, ohs[0], 0);
      if (n[0] == 753) check("hsync_post_pulse", 0, ohs[0], 1);
      if (n[1] == 47) begin
         check("small_x_at_wrap", 1, ox[1], 7);
         check("small_y_at_wrap", 1, oy[1], 5);
      end
      if (n[1] == 48 && enable) begin
         check("small_x_after_wrap", 1, ox[1], 0);
         check("small_y_after_wrap", 1, oy[1], 0);
         check("small_frame_start", 1, ofs[1], 1);
         check("small_line_start", 1, ols[1], 1);
      end
      if (n[0] == 0) de_cnt = 0;
      else if (n[0] <= 800) de_cnt += ode[0];
      if (n[0] == 800) check("de_clocks_per_line", 0, de_cnt, 640);
      if (n[1] == 0) vs_cnt = 0;
      else if (n[1] >= 4 && n[1] <= 51) vs_cnt += ovs[1];
      if (n[1] == 51) check("vsync_high_clocks", 1, vs_cnt, 8);
      if (n[2] == 3) check("first_pixel_color", 2, ocol[2], 60);
      if (wait_expired && !wait_reported) begin
         check("wait_bound", 0, 1, 0);
         wait_reported = 1'b1;
      end

      // model pixel generator: colour for the request seen LATENCY clocks ago, noise in blanking
      for (int i = 0; i < 3; i++) begin
         for (int k = 15; k > 0; k--) begin
            hx[i][k] = hx[i][k-1];
            hy[i][k] = hy[i][k-1];
         end
         hx[i][0] = ox[i];
         hy[i][0] = oy[i];
         gx = hx[i][lat[i]];
         gy = hy[i][lat[i]];
         gc = in_active(i, gx, gy) ? color_fn(i, gx, gy) : int'($urandom);
         if (i == 0) c_in0 = 8'(gc);
         else if (i == 1) c_in1 = 4'(gc);
         else c_in2 = 8'(gc);
      end
   end

   task automatic wait_for_x0(input int target);
      int cnt = 0;
      while (int'(px0) != target && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      if (int'(px0) != target) wait_expired = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (3000) @(negedge clk);

      wait_for_x0(300);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (500) @(negedge clk);

      wait_for_x0(100);
      enable = 1'b0;
      repeat (5) @(negedge clk);
      enable = 1'b1;
      repeat (1000) @(negedge clk);

      for (int seg = 0; seg < 12; seg++) begin
         repeat ($urandom_range(50, 1500)) @(negedge clk);
         if ($urandom_range(0, 1) == 0) begin
            reset = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            reset = 1'b1;
         end else begin
            enable = 1'b0;
            repeat ($urandom_range(1, 8)) @(negedge clk);
            enable = 1'b1;
         end
      end
      repeat (900) @(negedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_output.md
Name: vga_timing_output

Overview:
- Parametrised successor to the fixed 640x480 VGA output stage. Owns the horizontal and vertical counters internally instead of taking them from a separate counter block.
- Issues pixel coordinate requests to the pixel generator and absorbs that generator's fixed pipeline latency. HSync, VSync, DE and colour therefore leave the block mutually aligned.
- Sits between the pixel generator and the board VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, HSync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, VSync pulse width
- V_BP, 33, vertical back porch
- H_POL, 0, HSync active level (0 = active-low)
- V_POL, 0, VSync active level
- COLOR_W, 8, colour width (rrr_ggg_bb at 8)
- LATENCY, 2, clocks from pixel_x/pixel_y valid to matching color_in valid (0..15)
- X_W, 10, width of h counter/pixel_x; must hold H_TOTAL-1
- Y_W, 10, width of v counter/pixel_y; must hold V_TOTAL-1
- Derived localparams: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)

Ports:
- clk  in  1  pixel clock; single clock domain
- reset  in  1  synchronous, active-low reset
- enable  in  1  run timing; low = idle
- color_in  in  COLOR_W  pixel from generator, LATENCY clocks after request
- pixel_x  out  X_W  current h counter (request coordinate)
- pixel_y  out  Y_W  current v counter
- pixel_req  out  1  high when (pixel_x, pixel_y) lies in the active area
- frame_start  out  1  one-clock pulse when counters = (0,0)
- line_start  out  1  one-clock pulse when h counter = 0
- color  out  COLOR_W  registered output colour
- de  out  1  registered data-enable, aligned with color
- HSync  out  1  registered, aligned with color
- VSync  out  1  registered, aligned with color

Behaviour:
- Reset: while reset is low on a clk edge:
  - h and v counters go to 0.
  - color = 0, de = 0.
  - HSync = ~H_POL, VSync = ~V_POL.
  - All delay-line stages cleared to their inactive values.
  - pixel_req, frame_start and line_start are decoded from the counters, so they read as if at (0,0) and are gated low by enable = 0.
- Reset mid-frame takes effect on the next edge; no partial-line completion.
- enable low: same clear as reset, applied on each edge. The next rising enable starts at (0,0), so the first enabled cycle has frame_start = 1.
- Counters:
  - h increments every enabled clock and wraps H_TOTAL-1 -> 0.
  - v increments only on the h wrap and wraps V_TOTAL-1 -> 0.
  - Simultaneous h and v wrap gives (0,0) next.
- Stage-0 decodes, combinational from the counter registers and ANDed with enable:
  - active = h < H_ACTIVE && v < V_ACTIVE
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole-line granularity)
- pixel_req = active. frame_start = enable && h == 0 && v == 0. line_start = enable && h == 0.
- Alignment: active/hs/vs pass through a LATENCY-deep shift register. LATENCY = 0 means a direct path.
- Output register, at the delayed stage:
  - de <= active_d
  - color <= active_d ? color_in : 0
  - HSync <= hs_d ? H_POL : ~H_POL
  - VSync <= vs_d ? V_POL : ~V_POL
- Total latency from counter value to pins is LATENCY+1 clocks for color, de, HSync and VSync alike.
- color_in outside de is ignored; colour is forced to 0 in blanking.
- Polarity parameters only invert the driven level, never the timing.

Decomposition:
- Shared package vga_pkg:
  - 640x480@60 timing constants as named defaults
  - H_TOTAL/V_TOTAL computation
  - colour width constant
- One sub-module, vga_delay_line (parameter WIDTH, DEPTH; DEPTH = 0 is a wire). Instantiated once with WIDTH = 3 for {active, hs, vs}.

Test Plan:
- Default params, LATENCY = 0, enable = 1 from reset: HSync low exactly at h counts 656..751 (96 clocks), observed 1 clock later. Line period 800 clocks; frame period 420000 clocks.
- LATENCY = 2, color_in = f(pixel_x) driven by a 2-stage model generator: color at each de cycle equals the value for the matching x. de high exactly 640 clocks per line, 480 lines per frame.
- H_POL = 1, V_POL = 1: HSync high only during the pulse. VSync high for exactly 2 lines (v = 490,491) = 1600 clocks. Idle levels are 0.
- Pull reset low at (h = 300, v = 200) for 1 clock: next edge gives counters (0,0), color = 0, de = 0, syncs inactive. frame_start pulses on the first cycle after release.
- Drop enable for 5 clocks mid-line: outputs idle during the drop. Resume at (0,0) with frame_start = 1.
- Small params (H 4/1/2/1, V 3/1/1/1): check counter wrap at 7 -> 0 and v wrap 5 -> 0 on the same edge, plus line_start/frame_start coincidence.
